// File: rtl/cp0_irq_ctrl.sv
// Interrupt/exception sequencer beside CP0: Count/Compare timer, IP synchronisation and
// masking, commit-time arbitration and a one-cycle flush with redirect PC.
module cp0_irq_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          COUNT_DIV    = 2,
    parameter int          DRAIN_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [5:0]  i_hw_int,
    input  logic        i_status_ie,
    input  logic        i_status_exl,
    input  logic [7:0]  i_status_im,
    input  logic [1:0]  i_cause_ip_sw,
    input  logic        i_mtc0_we,
    input  logic [4:0]  i_mtc0_addr,
    input  logic [31:0] i_mtc0_wdata,
    input  logic        i_commit_valid,
    input  logic [31:0] i_commit_pc,
    input  logic        i_commit_in_ds,
    input  logic        i_stall,
    input  logic        i_except_req,
    input  logic [4:0]  i_exc_code,
    input  logic        i_eret_req,
    input  logic [31:0] i_epc,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic [7:0]  o_cause_ip,
    output logic        o_int_pending,
    output logic        o_flush,
    output logic [31:0] o_new_pc,
    output logic        o_int_take,
    output logic [4:0]  o_exc_code,
    output logic [31:0] o_exc_epc,
    output logic        o_exc_bd
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);
    localparam logic [DW-1:0] DRAIN_MAX = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DRAIN} state_t;

    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_drain;
    logic [PW-1:0] r_presc;
    logic [31:0]   r_count, r_compare;
    logic          r_timer_int;
    logic [5:0]    r_sync1, r_sync2;
    logic [31:0]   r_new_pc, r_exc_epc;
    logic [4:0]    r_exc_code;
    logic          r_exc_bd, r_is_int;

    logic          w_presc_wrap, w_count_we, w_compare_we, w_count_upd;
    logic [31:0]   w_count_nxt;
    logic [7:0]    w_ip;
    logic          w_int_pend, w_accept;

    // ---------------- timer ----------------
    assign w_presc_wrap = (r_presc == PRESC_MAX);
    assign w_count_we   = i_mtc0_we && (i_mtc0_addr == 5'd9);
    assign w_compare_we = i_mtc0_we && (i_mtc0_addr == 5'd11);
    assign w_count_upd  = w_count_we || w_presc_wrap;
    assign w_count_nxt  = w_count_we ? i_mtc0_wdata : r_count + 32'd1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_presc     <= '0;
            r_count     <= '0;
            r_compare   <= '0;
            r_timer_int <= 1'b0;
        end else begin
            if (w_count_we || w_presc_wrap) r_presc <= '0;
            else                            r_presc <= r_presc + PW'(1);
            if (w_count_upd) r_count <= w_count_nxt;
            // A Compare write always beats a coincident match.
            if (w_compare_we) begin
                r_compare   <= i_mtc0_wdata;
                r_timer_int <= 1'b0;
            end else if (w_count_upd && (w_count_nxt == r_compare)) begin
                r_timer_int <= 1'b1;
            end
        end
    end

    // ---------------- interrupt lines ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_hw_int;
            r_sync2 <= r_sync1;
        end
    end

    assign w_ip       = {r_sync2[5] | r_timer_int, r_sync2[4:0], i_cause_ip_sw};
    assign w_int_pend = i_status_ie && !i_status_exl && |(w_ip & i_status_im);
    assign w_accept   = (r_state == S_IDLE) && i_commit_valid && !i_stall &&
                        (w_int_pend || i_except_req || i_eret_req);

    // ---------------- sequencer FSM ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_drain <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_DRAIN) r_drain <= r_drain + DW'(1);
            else                    r_drain <= '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_drain == DRAIN_MAX) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Redirect payload is captured at acceptance and held until the next one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_new_pc   <= '0;
            r_exc_epc  <= '0;
            r_exc_code <= '0;
            r_exc_bd   <= 1'b0;
            r_is_int   <= 1'b0;
        end else if (w_accept) begin
            r_is_int <= w_int_pend;
            if (w_int_pend || i_except_req) begin
                r_new_pc   <= EXC_VECTOR;
                r_exc_code <= w_int_pend ? 5'd0 : i_exc_code;
                r_exc_epc  <= i_commit_in_ds ? i_commit_pc - 32'd4 : i_commit_pc;
                r_exc_bd   <= i_commit_in_ds;
            end else begin
                r_new_pc   <= i_epc;
                r_exc_code <= 5'd0;
            end
        end
    end

    always_comb begin
        o_flush    = (r_state == S_FLUSH);
        o_int_take = (r_state == S_FLUSH) && r_is_int;
    end

    assign o_count       = r_count;
    assign o_compare     = r_compare;
    assign o_cause_ip    = w_ip;
    assign o_int_pending = w_int_pend;
    assign o_new_pc      = r_new_pc;
    assign o_exc_code    = r_exc_code;
    assign o_exc_epc     = r_exc_epc;
    assign o_exc_bd      = r_exc_bd;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed bench for cp0_irq_ctrl: timer, IP sync/mask, arbitration, drain blocking, reset.
module tb_cp0_irq_ctrl;

    logic        clk, rst;
    logic [5:0]  hw_int;
    logic        ie, exl;
    logic [7:0]  im;
    logic [1:0]  sw;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        cvalid;
    logic [31:0] cpc;
    logic        ds, stall, exreq;
    logic [4:0]  excin;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] count, compare, new_pc, exc_epc;
    logic [7:0]  cause_ip;
    logic        int_pending, flush, int_take, exc_bd;
    logic [4:0]  exc_code;

    int n_checks = 0;
    int n_fail   = 0;

    cp0_irq_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_hw_int(hw_int), .i_status_ie(ie), .i_status_exl(exl),
        .i_status_im(im), .i_cause_ip_sw(sw), .i_mtc0_we(we), .i_mtc0_addr(addr),
        .i_mtc0_wdata(wdata), .i_commit_valid(cvalid), .i_commit_pc(cpc),
        .i_commit_in_ds(ds), .i_stall(stall), .i_except_req(exreq), .i_exc_code(excin),
        .i_eret_req(eret), .i_epc(epc), .o_count(count), .o_compare(compare),
        .o_cause_ip(cause_ip), .o_int_pending(int_pending), .o_flush(flush),
        .o_new_pc(new_pc), .o_int_take(int_take), .o_exc_code(exc_code),
        .o_exc_epc(exc_epc), .o_exc_bd(exc_bd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic wait_idle;
        repeat (4) step();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        hw_int = '0; ie = 0; exl = 0; im = '0; sw = '0; we = 0; addr = '0; wdata = '0;
        cvalid = 0; cpc = '0; ds = 0; stall = 0; exreq = 0; excin = '0; eret = 0; epc = '0;
        step();
        chk("rst_count", count, 32'd0);
        chk("rst_compare", compare, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_new_pc", new_pc, 32'd0);
        chk("rst_cause_ip", {24'd0, cause_ip}, 32'd0);
        chk("rst_exc_epc", exc_epc, 32'd0);
        rst = 1'b0;
    endtask

    task automatic test_count;
        test_reset();
        repeat (10) step();
        chk("count_10clk", count, 32'd5);
        #3 rst = 1'b1;
        #1 chk("count_async_rst", count, 32'd0);
        step();
        rst = 1'b0;
    endtask

    task automatic test_timer_int;
        ie = 1; exl = 0; im = 8'h80;
        mtc0(5'd11, 32'd6);
        mtc0(5'd9, 32'd0);
        chk("t2_ip7_early", {31'd0, cause_ip[7]}, 32'd0);
        for (int i = 0; i < 40 && !cause_ip[7]; i++) step();
        chk("t2_ip7_set", {31'd0, cause_ip[7]}, 32'd1);
        chk("t2_count_at_match", count, 32'd6);
        chk("t2_int_pending", {31'd0, int_pending}, 32'd1);
        cvalid = 1; cpc = 32'hBFC00200; ds = 0;
        step();
        cvalid = 0;
        chk("t2_flush", {31'd0, flush}, 32'd1);
        chk("t2_new_pc", new_pc, 32'hBFC00380);
        chk("t2_int_take", {31'd0, int_take}, 32'd1);
        chk("t2_exc_code", {27'd0, exc_code}, 32'd0);
        chk("t2_exc_epc", exc_epc, 32'hBFC00200);
        step();
        chk("t2_flush_pulse", {30'd0, flush, int_take}, 32'd0);
        chk("t2_new_pc_hold", new_pc, 32'hBFC00380);
        mtc0(5'd11, 32'hFFFF0000);
        chk("t2_ip7_cleared", {31'd0, cause_ip[7]}, 32'd0);
        ie = 0; im = '0;
    endtask

    task automatic test_compare_collision;
        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd9);
        step();
        chk("coll_count_pre", count, 32'd9);
        mtc0(5'd11, 32'd10);
        chk("coll_count_match", count, 32'd10);
        chk("coll_ip7_write_wins", {31'd0, cause_ip[7]}, 32'd0);
        step();
        chk("coll_ip7_stays", {31'd0, cause_ip[7]}, 32'd0);
    endtask

    task automatic test_delay_slot;
        wait_idle();
        ie = 1; exl = 0; im = 8'h01; sw = 2'b01;
        cvalid = 1; cpc = 32'hBFC00104; ds = 1;
        step();
        cvalid = 0;
        chk("t3_flush", {31'd0, flush}, 32'd1);
        chk("t3_int_take", {31'd0, int_take}, 32'd1);
        chk("t3_exc_epc", exc_epc, 32'hBFC00100);
        chk("t3_exc_bd", {31'd0, exc_bd}, 32'd1);
        ds = 0;
    endtask

    task automatic test_priority;
        wait_idle();
        exreq = 1; excin = 5'h8; cvalid = 1; cpc = 32'h80000040;
        step();
        cvalid = 0; exreq = 0;
        chk("t4_flush", {31'd0, flush}, 32'd1);
        chk("t4_int_wins", {31'd0, int_take}, 32'd1);
        chk("t4_code_int", {27'd0, exc_code}, 32'd0);
        chk("t4_exc_epc", exc_epc, 32'h80000040);
        chk("t4_exc_bd", {31'd0, exc_bd}, 32'd0);
        wait_idle();
        exl = 1;
        #1 chk("t4_exl_masks", {31'd0, int_pending}, 32'd0);
        exreq = 1; cvalid = 1; cpc = 32'h80000080;
        step();
        cvalid = 0; exreq = 0;
        chk("t4_exc_flush", {31'd0, flush}, 32'd1);
        chk("t4_exc_int_take", {31'd0, int_take}, 32'd0);
        chk("t4_exc_code", {27'd0, exc_code}, 32'd8);
        chk("t4_exc_new_pc", new_pc, 32'hBFC00380);
        exl = 0; sw = 0;
    endtask

    task automatic test_back_to_back;
        wait_idle();
        ie = 0; eret = 1; epc = 32'h80001000; cvalid = 1;
        step();
        eret = 0;
        chk("t5_eret_flush", {31'd0, flush}, 32'd1);
        chk("t5_eret_new_pc", new_pc, 32'h80001000);
        chk("t5_eret_int_take", {31'd0, int_take}, 32'd0);
        chk("t5_eret_code", {27'd0, exc_code}, 32'd0);
        ie = 1; im = 8'h01; sw = 2'b01; cpc = 32'h80002000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_drain_blocks", {31'd0, flush}, 32'd0);
        end
        step();
        cvalid = 0;
        chk("t5_after_drain_flush", {31'd0, flush}, 32'd1);
        chk("t5_after_drain_int", {31'd0, int_take}, 32'd1);
        chk("t5_after_drain_epc", exc_epc, 32'h80002000);
        sw = 0;
    endtask

    task automatic test_hw_sync;
        wait_idle();
        ie = 1; exl = 0; im = 8'h10; hw_int = 6'b000100;
        step();
        chk("t6_sync_1clk", {31'd0, int_pending}, 32'd0);
        step();
        chk("t6_sync_2clk", {31'd0, int_pending}, 32'd1);
        chk("t6_cause_ip", {24'd0, cause_ip}, 32'h10);
        step();
        hw_int = '0;
        step();
        chk("t6_hold", {31'd0, int_pending}, 32'd1);
        step();
        chk("t6_fall", {31'd0, int_pending}, 32'd0);
        exl = 1; hw_int = 6'b000100; cvalid = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t6_exl_no_flush", {30'd0, flush, int_pending}, 32'd0);
        end
        chk("t6_exl_ip4", {31'd0, cause_ip[4]}, 32'd1);
        cvalid = 0; hw_int = '0; exl = 0;
    endtask

    task automatic test_reset_in_flush;
        repeat (4) step();
        ie = 1; im = 8'h01; sw = 2'b01; cvalid = 1; cpc = 32'h80003000;
        step();
        cvalid = 0;
        chk("rf_flush", {31'd0, flush}, 32'd1);
        #2 rst = 1'b1;
        #1 chk("rf_flush_cleared", {30'd0, flush, int_take}, 32'd0);
        chk("rf_new_pc_cleared", new_pc, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("rf_idle_after", {31'd0, flush}, 32'd0);
    endtask

    initial begin
        test_reset();
        test_count();
        test_timer_int();
        test_compare_collision();
        test_delay_slot();
        test_priority();
        test_back_to_back();
        test_hw_sync();
        test_reset_in_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
